pipe_adder: RTL
===============

Name: pipe_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder for the multiplier datapath. It serves the final carry-propagate add and the partial-product accumulation paths.
- The carry chain is split into SEG-bit segments, with one register stage per segment, so the critical path is one SEG-bit ripple regardless of WIDTH.
- Valid/ready handshake on both sides. The whole pipeline stalls together under backpressure.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, segment width in bits, i.e. carry bits resolved per pipeline stage.
- NSTG, WIDTH/SEG, derived stage count and latency. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin present.
- in_ready  output  1  pipeline accepts the operand set this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum, cout, ovf valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  unsigned carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - All stage valid bits 0, all data registers 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 (it is combinational from the last-stage valid).
- Acceptance: a transfer occurs on a clk edge where in_valid && in_ready. Output handshake completes on out_valid && out_ready.
- Stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance=0, every stage register holds, including the bubbles.
  - No per-stage bubble collapsing.
- Stage k, for k = 0..NSTG-1:
  - Adds segment k of the operands, bits [k*SEG +: SEG], plus the carry from stage k-1. Stage 0 uses cin.
  - Registers the result together with the resolved low sum bits, the unprocessed high operand bits, and the carry.
  - Operand bits already consumed are not carried forward.
- Last stage:
  - Registers sum, cout (carry out of segment NSTG-1), and ovf (computed from the MSB carry-in/carry-out inside the final segment).
- Latency and throughput:
  - Latency is exactly NSTG cycles from the accepting edge to out_valid=1, with no backpressure.
  - Throughput is one result per cycle when out_ready is held high.
- Ordering: results emerge in acceptance order; none are dropped or duplicated.
- Hold: while out_valid=1 && out_ready=0, the outputs are held stable and inputs are not accepted.
- Simultaneous events: a new input accept and an output retire on the same edge are legal, so a full pipeline sustains rate.
- Reset mid-operation: all in-flight results are discarded immediately (asynchronously). The first accept after release follows normal latency.
- Wrap-around: 0xFFFF + 0x0001 wraps to 0x0000 with cout=1. No saturation.
- Degenerate sizes: NSTG=1 (SEG=WIDTH) is legal and gives 1-cycle latency.
- Elaboration errors: WIDTH % SEG != 0 or SEG < 1 must be a generate-time error.

Decomposition:
- Shared package holds no typedefs. It carries one constant function, clog2, for benches and future sizing.
- One sub-module, seg_add: a combinational SEG-bit ripple adder with cin and cout, plus a carry-into-MSB output for ovf.
- seg_add is instantiated NSTG times in a generate loop. Pipeline registers live in pipe_adder.

Test Plan (WIDTH=16, SEG=4, latency 4):
- a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
- Throughput: 8 back-to-back random pairs with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model; in_ready stays 1.
- Backpressure: fill the pipeline, drop out_ready for 5 cycles -> in_ready=0 and sum/cout frozen. Restore -> remaining results are delivered in order, none lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 results in flight, mid-cycle -> out_valid=0 and sum=0 immediately. After release, new operand a=0x1234, b=0x4321 -> sum=0x5555 after 4 cycles.
- Random soak: 10k random a, b, cin with random out_ready and in_valid -> scoreboard matches (a+b+cin), cout and ovf. Also run SEG=16, where latency must be 1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder family.
// Holds no types; clog2 is kept here for benches and future sizing.
package pipe_adder_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The master drives operands and out_ready; the slave is the adder.
interface pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder_seg_add.sv
// Combinational SEG-bit ripple adder; one instance per pipeline stage.
// cmsb is the carry into the top bit, needed for signed overflow.
module seg_add
   import pipe_adder_pkg::*;
#(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout,
   output logic           cmsb
);
   logic c;

   always_comb begin
      c    = cin;
      s    = '0;
      cmsb = cin;
      for (int i = 0; i < SEG; i++) begin
         if (i == SEG - 1) cmsb = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: one SEG-bit ripple segment per register stage.
// The whole pipeline advances or holds together; bubbles are not collapsed.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_adder_if.slave bus
);
   localparam int NSTG = (SEG >= 1) ? WIDTH / SEG : 1;

   if (SEG < 1) begin : g_bad_seg
      $error("pipe_adder: SEG must be at least 1");
   end else if ((WIDTH % SEG) != 0) begin : g_bad_width
      $error("pipe_adder: WIDTH must be a multiple of SEG");
   end

   logic             adv;
   logic             vld_p [NSTG];
   logic             c_p   [NSTG];
   logic [WIDTH-1:0] sum_p [NSTG];
   logic [WIDTH-1:0] a_p   [NSTG];
   logic [WIDTH-1:0] b_p   [NSTG];
   logic             ovf_p;

   assign adv           = !vld_p[NSTG-1] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_p[NSTG-1];
   assign bus.sum       = sum_p[NSTG-1];
   assign bus.cout      = c_p[NSTG-1];
   assign bus.ovf       = ovf_p;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      logic             vi;
      logic             ci;
      logic [WIDTH-1:0] ai;
      logic [WIDTH-1:0] bi;
      logic [WIDTH-1:0] si;
      logic [WIDTH-1:0] sn;
      logic [SEG-1:0]   ss;
      logic             co;
      logic             cm;

      if (k == 0) begin : g_head
         assign vi = bus.in_valid;
         assign ai = bus.a;
         assign bi = bus.b;
         assign ci = bus.cin;
         assign si = '0;
      end else begin : g_body
         assign vi = vld_p[k-1];
         assign ai = a_p[k-1];
         assign bi = b_p[k-1];
         assign ci = c_p[k-1];
         assign si = sum_p[k-1];
      end

      seg_add #(.SEG(SEG)) u_seg (
         .a    (ai[SEG-1:0]),
         .b    (bi[SEG-1:0]),
         .cin  (ci),
         .s    (ss),
         .cout (co),
         .cmsb (cm)
      );

      always_comb begin
         sn                = si;
         sn[k*SEG +: SEG]  = ss;
      end

      // Stage k register: resolved low sum, carry, and the still-unused operand bits shifted down
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_p[k] <= 1'b0;
            c_p[k]   <= 1'b0;
            sum_p[k] <= '0;
            a_p[k]   <= '0;
            b_p[k]   <= '0;
         end else if (adv) begin
            vld_p[k] <= vi;
            c_p[k]   <= co;
            sum_p[k] <= sn;
            a_p[k]   <= ai >> SEG;
            b_p[k]   <= bi >> SEG;
         end
      end

      if (k == NSTG - 1) begin : g_tail
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   ovf_p <= 1'b0;
            else if (adv) ovf_p <= cm ^ co;
         end
      end
   end
endmodule
